// File: rtl/rice_stream_packer_pkg.sv
// Shared definitions for the Rice coding blocks: command encodings, packer FSM
// states and the default word / Rice-parameter widths.
package rice_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int Q_W_DEF    = 16;
  localparam int K_W_DEF    = 5;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    CMD_CODE  = 2'b00,
    CMD_PARAM = 2'b01,
    CMD_FLUSH = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CODE,
    ST_ZERO,
    ST_TAIL,
    ST_PARAM,
    ST_FLUSH,
    ST_FLUSH_WAIT
  } state_e;

endpackage

// File: rtl/rice_stream_packer_if.sv
// Command input and word output handshakes of the Rice stream packer.
// The slave modport is the packer's view; master is the surrounding pipeline's.
interface rice_stream_packer_if
  import rice_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int Q_W    = Q_W_DEF,
  parameter int K_W    = K_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              iValid;
  logic              oReady;
  logic [1:0]        iCmd;
  logic [Q_W-1:0]    iQuotient;
  logic [WORD_W-2:0] iRemainder;
  logic [K_W-1:0]    iRiceParam;
  logic              oValid;
  logic              iReady;
  logic [WORD_W-1:0] oData;
  logic [ADDR_W-1:0] oAddress;
  logic              oLast;
  logic              oFlushDone;
  logic [CNT_W-1:0]  oBitCount;

  modport slave (
    input  iValid, iCmd, iQuotient, iRemainder, iRiceParam, iReady,
    output oReady, oValid, oData, oAddress, oLast, oFlushDone, oBitCount
  );

  modport master (
    output iValid, iCmd, iQuotient, iRemainder, iRiceParam, iReady,
    input  oReady, oValid, oData, oAddress, oLast, oFlushDone, oBitCount
  );
endinterface

// File: rtl/rice_bit_accumulator.sv
// 2*WORD_W left-aligned bit accumulator: appends variable-length fields below
// the valid bits and pops the top word. Bits below the fill point stay zero.
module rice_bit_accumulator #(
  parameter int WORD_W = 16,
  parameter int LEN_W  = $clog2(2 * WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              append_i,
  input  logic [LEN_W-1:0]  append_len_i,
  input  logic [WORD_W-1:0] append_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] word_o,
  output logic [LEN_W-1:0]  fill_o
);
  localparam int ACC_W = 2 * WORD_W;
  localparam int SH_W  = LEN_W + 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [ACC_W-1:0] mask;
  logic [SH_W-1:0]  shift;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    mask   = (ACC_W'(1) << append_len_i) - ACC_W'(1);
    shift  = SH_W'(ACC_W) - SH_W'(fill_q) - SH_W'(append_len_i);
    if (append_i) begin
      acc_d  = acc_q | ((ACC_W'(append_data_i) & mask) << shift);
      fill_d = fill_q + append_len_i;
    end else if (pop_i) begin
      // A pop below one full word is the flush pad: the zero tail comes along.
      acc_d  = acc_q << WORD_W;
      fill_d = (fill_q >= LEN_W'(WORD_W)) ? fill_q - LEN_W'(WORD_W) : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign word_o = acc_q[ACC_W-1 -: WORD_W];
  assign fill_o = fill_q;
endmodule

// File: rtl/rice_stream_packer.sv
// Packs Rice codewords, Rice-parameter fields and flush padding into WORD_W-bit
// words on a valid/ready output carrying the word index within the frame.
module rice_stream_packer
  import rice_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int Q_W    = Q_W_DEF,
  parameter int K_W    = K_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic                 iClock,
  input logic                 iReset_n,
  rice_stream_packer_if.slave bus
);
  localparam int LEN_W = $clog2(2 * WORD_W);

  state_e            state_q;
  logic [Q_W-1:0]    zrem_q;
  logic [WORD_W-2:0] rem_q;
  logic [K_W-1:0]    field_q;
  logic [WORD_W-1:0] out_data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              out_valid_q, out_last_q, done_q;
  logic [CNT_W-1:0]  cnt_q, bitcnt_q;

  logic [LEN_W-1:0]  fill, app_len, k_sat;
  logic [WORD_W-1:0] app_data, acc_word, k_bit;
  logic              fill_low, hold_free, append, pop, accept, flush_done;

  rice_bit_accumulator #(.WORD_W(WORD_W), .LEN_W(LEN_W)) u_acc (
    .clk          (iClock),
    .rst_n        (iReset_n),
    .append_i     (append),
    .append_len_i (app_len),
    .append_data_i(app_data),
    .pop_i        (pop),
    .word_o       (acc_word),
    .fill_o       (fill)
  );

  always_comb begin
    fill_low  = (fill < LEN_W'(WORD_W));
    hold_free = !out_valid_q || bus.iReady;
    k_sat     = (int'(field_q) > WORD_W - 1) ? LEN_W'(WORD_W - 1) : LEN_W'(field_q);
    k_bit     = WORD_W'(1) << k_sat;
    append    = 1'b0;
    app_len   = '0;
    app_data  = '0;
    unique case (state_q)
      ST_ZERO: begin
        append  = fill_low;
        app_len = (zrem_q > Q_W'(WORD_W)) ? LEN_W'(WORD_W) : LEN_W'(zrem_q);
      end
      ST_TAIL: begin
        append   = fill_low;
        app_len  = k_sat + LEN_W'(1);
        app_data = k_bit | (WORD_W'(rem_q) & (k_bit - WORD_W'(1)));
      end
      ST_PARAM: begin
        append   = fill_low;
        app_len  = LEN_W'(K_W);
        app_data = WORD_W'(field_q);
      end
      default: ;
    endcase
    pop        = hold_free && (!fill_low || (state_q == ST_FLUSH && fill != '0));
    flush_done = (state_q == ST_FLUSH && fill == '0 && hold_free) ||
                 (state_q == ST_FLUSH_WAIT && out_valid_q && bus.iReady);
  end

  assign bus.oReady = (state_q == ST_IDLE) && fill_low;
  assign accept     = bus.iValid && bus.oReady;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= ST_IDLE;
      zrem_q      <= '0;
      rem_q       <= '0;
      field_q     <= '0;
      out_data_q  <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
    end else begin
      done_q <= flush_done;
      if (pop) begin
        out_data_q  <= acc_word;
        out_valid_q <= 1'b1;
        out_last_q  <= fill_low;
      end else if (out_valid_q && bus.iReady) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (flush_done)                     addr_q <= '0;
      else if (out_valid_q && bus.iReady) addr_q <= addr_q + ADDR_W'(1);
      if (flush_done) begin
        bitcnt_q <= cnt_q;
        cnt_q    <= '0;
      end else if (append) begin
        cnt_q <= cnt_q + CNT_W'(app_len);
      end

      unique case (state_q)
        ST_IDLE: if (accept) begin
          case (bus.iCmd)
            CMD_CODE: begin
              zrem_q  <= bus.iQuotient;
              rem_q   <= bus.iRemainder;
              field_q <= bus.iRiceParam;
              state_q <= ST_CODE;
            end
            CMD_PARAM: begin
              field_q <= bus.iRiceParam;
              state_q <= ST_PARAM;
            end
            CMD_FLUSH: state_q <= ST_FLUSH;
            default:   ;
          endcase
        end
        ST_CODE: state_q <= (zrem_q != '0) ? ST_ZERO : ST_TAIL;
        ST_ZERO: if (fill_low) begin
          zrem_q <= zrem_q - Q_W'(app_len);
          if (zrem_q <= Q_W'(WORD_W)) state_q <= ST_TAIL;
        end
        ST_TAIL, ST_PARAM: if (fill_low) state_q <= ST_IDLE;
        ST_FLUSH: if (fill_low && hold_free) state_q <= (fill != '0) ? ST_FLUSH_WAIT : ST_IDLE;
        ST_FLUSH_WAIT: if (out_valid_q && bus.iReady) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.oValid     = out_valid_q;
  assign bus.oData      = out_data_q;
  assign bus.oAddress   = addr_q;
  assign bus.oLast      = out_last_q;
  assign bus.oFlushDone = done_q;
  assign bus.oBitCount  = bitcnt_q;
endmodule

// File: tb/tb_rice_stream_packer.sv
// Directed bench for rice_stream_packer with default parameters: hand-computed
// words, addresses, last flags and flush bit counts for each scenario.
module tb_rice_stream_packer;
  import rice_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] addr;
    logic        last;
  } word_t;

  word_t       got[$];
  logic [31:0] dones[$];

  rice_stream_packer_if bus ();

  rice_stream_packer dut (
    .iClock  (clk),
    .iReset_n(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Record accepted words and flush pulses half a cycle before the accepting edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.oValid === 1'b1 && bus.iReady === 1'b1)
        got.push_back('{data: bus.oData, addr: bus.oAddress, last: bus.oLast});
      if (bus.oFlushDone === 1'b1) dones.push_back(bus.oBitCount);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] cmd, input logic [15:0] q,
                      input logic [14:0] r, input logic [4:0] k);
    bit took = 1'b0;
    bus.iCmd = cmd; bus.iQuotient = q; bus.iRemainder = r; bus.iRiceParam = k;
    bus.iValid = 1'b1;
    for (int t = 0; t < 200 && !took; t++) begin
      took = (bus.oReady === 1'b1);
      step();
    end
    bus.iValid = 1'b0;
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL send_accept: cmd=%0d not accepted within 200 cycles", cmd);
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (dones.size() == 0 && t < 300) begin step(); t++; end
    repeat (3) step();
    checks++;
    if (dones.size() == 0) begin
      errors++;
      $display("FAIL %s_done: no oFlushDone within 300 cycles", name);
    end
  endtask

  task automatic clear_logs();
    got.delete();
    dones.delete();
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({bus.oValid, bus.oData, bus.oAddress, bus.oLast, bus.oFlushDone, bus.oBitCount} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h addr=%0d last=%b done=%b cnt=%0d, want all 0",
               bus.oValid, bus.oData, bus.oAddress, bus.oLast, bus.oFlushDone, bus.oBitCount);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.oReady !== 1'b1 || bus.oValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: oReady=%b oValid=%b, want 1 0", bus.oReady, bus.oValid);
    end
  endtask

  // CODE q=2 k=3 r=5 -> 001 101, padded to 0x3400.
  task automatic test_code_basic(input string name);
    clear_logs();
    send(CMD_CODE, 16'd2, 15'd5, 5'd3);
    send(CMD_FLUSH, 16'd0, 15'd0, 5'd0);
    wait_done(name);
    checks++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL %s_count: %0d words, want 1", name, got.size());
    end else if (got[0] !== word_t'({16'h3400, 16'd0, 1'b1})) begin
      errors++;
      $display("FAIL %s_word: data=%h addr=%0d last=%b, want 3400 0 1",
               name, got[0].data, got[0].addr, got[0].last);
    end
    checks++;
    if (dones.size() != 1 || dones[0] !== 32'd6) begin
      errors++;
      $display("FAIL %s_bitcount: %0d pulses, first=%0d, want 1 pulse of 6",
               name, dones.size(), dones.size() > 0 ? dones[0] : 32'd0);
    end
  endtask

  // CODE q=40 k=0 -> 40 zeros and a stop bit: 0000@0, 0000@1, 0080@2 last.
  task automatic test_long_run(input bit stall);
    word_t exp_w[3];
    int    t = 0;
    exp_w[0] = '{data: 16'h0000, addr: 16'd0, last: 1'b0};
    exp_w[1] = '{data: 16'h0000, addr: 16'd1, last: 1'b0};
    exp_w[2] = '{data: 16'h0080, addr: 16'd2, last: 1'b1};
    clear_logs();
    bus.iReady = !stall;
    send(CMD_CODE, 16'd40, 15'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.oReady !== 1'b0) begin
        errors++;
        $display("FAIL long_ready_low: oReady=%b during zero run, want 0", bus.oReady);
      end
      step();
    end
    if (stall) begin
      while (bus.oValid !== 1'b1 && t < 50) begin step(); t++; end
      for (int i = 0; i < 10; i++) begin
        checks++;
        if ({bus.oValid, bus.oData, bus.oAddress, bus.oLast} !== {1'b1, 16'h0000, 16'd0, 1'b0}) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h addr=%0d last=%b, want 1 0000 0 0",
                   bus.oValid, bus.oData, bus.oAddress, bus.oLast);
        end
        step();
      end
      bus.iReady = 1'b1;
    end
    send(CMD_FLUSH, 16'd0, 15'd0, 5'd0);
    wait_done("long");
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL long_count: %0d words, want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL long_word%0d: data=%h addr=%0d last=%b, want %h %0d %b", i,
                   got[i].data, got[i].addr, got[i].last, exp_w[i].data, exp_w[i].addr, exp_w[i].last);
        end
      end
    end
    checks++;
    if (dones.size() != 1 || dones[0] !== 32'd41) begin
      errors++;
      $display("FAIL long_bitcount: %0d pulses, first=%0d, want 1 pulse of 41",
               dones.size(), dones.size() > 0 ? dones[0] : 32'd0);
    end
  endtask

  // Exactly one full word (with k=15, or k=20 saturated to 15), then an empty flush.
  task automatic test_full_word(input logic [4:0] k, input string name);
    int t = 0;
    clear_logs();
    send(CMD_CODE, 16'd0, 15'h7FFF, k);
    while (got.size() == 0 && t < 30) begin step(); t++; end
    repeat (2) step();
    checks++;
    if (got.size() != 1 || dones.size() != 0) begin
      errors++;
      $display("FAIL %s_count: %0d words %0d pulses, want 1 0", name, got.size(), dones.size());
    end else if (got[0] !== word_t'({16'hFFFF, 16'd0, 1'b0})) begin
      errors++;
      $display("FAIL %s_word: data=%h addr=%0d last=%b, want ffff 0 0",
               name, got[0].data, got[0].addr, got[0].last);
    end
    send(CMD_FLUSH, 16'd0, 15'd0, 5'd0);
    wait_done(name);
    checks++;
    if (got.size() != 1 || dones.size() != 1 || dones[0] !== 32'd16) begin
      errors++;
      $display("FAIL %s_flush: %0d words %0d pulses first=%0d, want 1 1 16", name,
               got.size(), dones.size(), dones.size() > 0 ? dones[0] : 32'd0);
    end
    checks++;
    if (bus.oAddress !== 16'd0) begin
      errors++;
      $display("FAIL %s_addr_reset: oAddress=%0d after flush, want 0", name, bus.oAddress);
    end
  endtask

  // PARAM 7 -> 00111, CODE q=0 k=7 r=0x55 -> 1 1010101: 0x3EA8, 13 bits.
  task automatic test_param();
    clear_logs();
    send(CMD_PARAM, 16'd0, 15'd0, 5'd7);
    send(CMD_CODE, 16'd0, 15'h0055, 5'd7);
    send(CMD_FLUSH, 16'd0, 15'd0, 5'd0);
    wait_done("param");
    checks++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL param_count: %0d words, want 1", got.size());
    end else if (got[0] !== word_t'({16'h3EA8, 16'd0, 1'b1})) begin
      errors++;
      $display("FAIL param_word: data=%h addr=%0d last=%b, want 3ea8 0 1",
               got[0].data, got[0].addr, got[0].last);
    end
    checks++;
    if (dones.size() != 1 || dones[0] !== 32'd13) begin
      errors++;
      $display("FAIL param_bitcount: %0d pulses, first=%0d, want 1 pulse of 13",
               dones.size(), dones.size() > 0 ? dones[0] : 32'd0);
    end
  endtask

  task automatic test_reserved_empty_flush();
    clear_logs();
    send(CMD_RSVD, 16'd9, 15'h1234, 5'd3);
    send(CMD_FLUSH, 16'd0, 15'd0, 5'd0);
    wait_done("reserved");
    checks++;
    if (got.size() != 0 || dones.size() != 1 || dones[0] !== 32'd0) begin
      errors++;
      $display("FAIL reserved_noop: %0d words %0d pulses first=%0d, want 0 1 0",
               got.size(), dones.size(), dones.size() > 0 ? dones[0] : 32'd0);
    end
  endtask

  task automatic test_reset_mid_zero();
    int t = 0;
    clear_logs();
    bus.iReady = 1'b0;
    send(CMD_CODE, 16'd40, 15'd0, 5'd0);
    while (bus.oValid !== 1'b1 && t < 50) begin step(); t++; end
    repeat (4) step();
    checks++;
    if (bus.oValid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup: oValid=%b before reset, want 1", bus.oValid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oValid, bus.oAddress, bus.oLast, bus.oData} !== '0) begin
      errors++;
      $display("FAIL midreset_clear: valid=%b addr=%0d last=%b data=%h, want all 0",
               bus.oValid, bus.oAddress, bus.oLast, bus.oData);
    end
    step();
    rst_n = 1'b1;
    bus.iReady = 1'b1;
    step();
    test_code_basic("after_reset");
  endtask

  initial begin
    bus.iValid = 1'b0;
    bus.iCmd = 2'b00;
    bus.iQuotient = '0;
    bus.iRemainder = '0;
    bus.iRiceParam = '0;
    bus.iReady = 1'b1;
    test_reset();
    test_code_basic("basic");
    test_long_run(1'b0);
    test_full_word(5'd15, "full");
    test_code_basic("next_frame");
    test_param();
    test_long_run(1'b1);
    test_full_word(5'd20, "ksat");
    test_reserved_empty_flush();
    test_reset_mid_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rice_stream_packer.md
Name: rice_stream_packer

Overview:
- Parametrised successor to the current Rice writer; packs FLAC Rice codewords (unary quotient, stop bit, k-bit remainder), Rice-parameter fields and flush/pad commands into a stream of WORD_W-bit words.
- Replaces the dual RAM write port with a single valid/ready output carrying a word address.
- Quotient length is unbounded within Q_W: long unary runs are emitted one word per cycle under back-pressure, not by skipping addresses.
- Sits between the residual/Rice-parameter stage and the frame RAM or bit-stream assembler.

Parameters:
- WORD_W, 16, output word width in bits (power of two, >= 8).
- Q_W, 16, width of the quotient (unary zero count).
- K_W, 5, width of the Rice-parameter field written by a PARAM command (4 or 5 in FLAC).
- ADDR_W, 16, output word address width.
- CNT_W, 32, frame bit-count width.

Ports:
- iClock  in  1  clock.
- iReset_n  in  1  asynchronous, active-low reset.
- iValid  in  1  command valid.
- oReady  out  1  block accepts a command this cycle.
- iCmd  in  2  command: 00 CODE, 01 PARAM, 10 FLUSH, 11 reserved (accepted, no effect).
- iQuotient  in  Q_W  number of unary zeros (CODE).
- iRemainder  in  WORD_W-1  remainder; bits at and above k are ignored (CODE).
- iRiceParam  in  K_W  k for CODE; the field value for PARAM.
- oValid  out  1  output word valid.
- iReady  in  1  downstream accepts the output word.
- oData  out  WORD_W  packed word, MSB first in time.
- oAddress  out  ADDR_W  word index within the current frame.
- oLast  out  1  word is the padded final word of a flush.
- oFlushDone  out  1  one-cycle pulse when a flush completes.
- oBitCount  out  CNT_W  unpadded bits written since the previous flush; valid while oFlushDone is high.

Behaviour:
- Reset (iReset_n low, asynchronous) clears all state: oValid=0, oData=0, oAddress=0, oLast=0, oFlushDone=0, oBitCount=0. Internal accumulator fill=0, state IDLE.
- Internal state: accumulator of 2*WORD_W bits, fill counter 0..2*WORD_W-1, output holding register.
- Emission: when fill >= WORD_W and the holding register is free (oValid=0, or oValid&&iReady), move the top WORD_W bits to oData and set oValid. The accumulator shifts left and fill -= WORD_W. oAddress increments after each accepted word.
- Output handshake: oData, oAddress and oLast are held stable while oValid&&!iReady. Words are never dropped or duplicated.
- Append rule: bits are appended only in a cycle that starts with fill < WORD_W, at most WORD_W bits per cycle.
- oReady = (state==IDLE) && (fill < WORD_W). A command is taken on iValid&&oReady.
- FSM states:
  - IDLE: accepts commands.
  - CODE: latch q, r and k; if q>0 go to ZERO, else TAIL.
  - ZERO: each append cycle adds min(zrem, WORD_W) zeros; go to TAIL when zrem reaches 0.
  - TAIL: appends the stop bit 1 followed by the k remainder bits (1+k <= WORD_W), then returns to IDLE.
  - PARAM: appends iRiceParam as K_W bits in one cycle, then IDLE.
  - FLUSH: wait for fill < WORD_W. If fill > 0, pad with zeros to WORD_W and emit with oLast=1. After that word is accepted, pulse oFlushDone with oBitCount. If fill==0, pulse oFlushDone without emitting a word. Afterwards reset oAddress and the bit count to 0, then IDLE.
- k saturation: for CODE, k > WORD_W-1 is saturated to WORD_W-1.
- Bit count: counts all appended bits before padding and wraps modulo 2^CNT_W.
- Address: oAddress wraps modulo 2^ADDR_W.
- Minimum latency: a command completing a word raises oValid on the next cycle.
- Throughput: a CODE takes ceil(q/WORD_W)+1 append cycles when not back-pressured.
- Reset mid-operation: abandons the partial word and any in-flight output word. The next command after reset starts at address 0.

Decomposition:
- Shared package rice_pkg holds:
  - command encodings CMD_CODE, CMD_PARAM, CMD_FLUSH;
  - the FSM state enum;
  - the default WORD_W/K_W constants, reused by the Rice parameter estimator.
- One natural sub-module: rice_bit_accumulator, the 2*WORD_W shift register with fill counter. It provides variable-length append and word-pop interfaces; the top level owns the FSM and handshakes.

Test Plan:
- CODE q=2,k=3,r=5; FLUSH -> one word oData=0x3400, oAddress=0, oLast=1; then oFlushDone with oBitCount=6.
- CODE q=40,k=0; FLUSH -> 0x0000@0, 0x0000@1, 0x0080@2 with oLast=1; oBitCount=41; oReady low during ZERO.
- CODE q=0,k=15,r=0x7FFF -> 0xFFFF@0 emitted without flush. Then FLUSH -> no word, oFlushDone pulse, oBitCount=16, and the next frame starts at address 0.
- PARAM 7 (K_W=5); CODE q=0,k=7,r=0x55; FLUSH -> 0x3EA8@0, oLast=1, oBitCount=13.
- Repeat the q=40 case with iReady held low 10 cycles on the first word -> oData/oAddress stable throughout, same three words in order, no loss or duplicate.
- Drive iReset_n low mid-ZERO with oValid high -> oValid=0, oAddress=0 immediately. After release, CODE q=2,k=3,r=5 plus FLUSH yields 0x3400@0.
